// File: rtl/intpol2_d4_ctrl_fsm.sv
// Control state machine for the second-order, factor-4 interpolator.
// Sequences window prefetch (FILL/LOAD), per-sample output phases (CALC),
// next-sample fetch (NEXT) and the end-of-run pulse (DONE). All strobes are
// combinational decodes of the registered state, phase and current inputs,
// so FIFO flags gate traffic in the very cycle they are seen.
module intpol2_d4_ctrl_fsm #(
    parameter int PH_BITS = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clear,
    input  logic               start,
    input  logic               mode,
    input  logic               Empty,
    input  logic               Afull,
    input  logic               comp_addr,
    input  logic               comp_cnt,
    output logic               busy,
    output logic               done,
    output logic               en_M_addr,
    output logic               Read_Enable,
    output logic               Write_Enable,
    output logic               en_sum,
    output logic [PH_BITS-1:0] phase
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        LOAD,
        CALC,
        NEXT,
        DONE
    } state_t;

    localparam logic [PH_BITS-1:0] PH_LAST = '1;

    state_t state;
    logic   mode_r;
    logic   last_ph;

    // Output decode: strobes depend on state, phase and the live FIFO flags.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        en_M_addr    = 1'b0;
        Read_Enable  = 1'b0;
        Write_Enable = 1'b0;
        en_sum       = 1'b0;
        // Pass-through emits a single write per input, so phase 0 is final.
        last_ph      = mode_r ? (phase == '0) : (phase == PH_LAST);
        case (state)
            FILL: begin
                busy = 1'b1;
            end
            LOAD: begin
                busy = 1'b1;
                // An empty FIFO before the window is complete aborts the
                // prefetch; dropping en_M_addr restarts its counter.
                if (!(Empty && !comp_addr)) begin
                    en_M_addr   = 1'b1;
                    Read_Enable = ~comp_addr;
                end
            end
            CALC: begin
                busy         = 1'b1;
                Write_Enable = ~Afull;
                en_sum       = ~Afull & last_ph;
            end
            NEXT: begin
                busy        = 1'b1;
                Read_Enable = ~Empty;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State, phase and latched mode; clear overrides every transition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            phase  <= '0;
            mode_r <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (!Empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (comp_addr) begin
                        state <= CALC;
                        phase <= '0;
                    end else if (Empty) begin
                        state <= FILL;
                    end
                end
                CALC: begin
                    // Afull holds phase; comp_cnt is judged before en_sum lands.
                    if (Write_Enable) begin
                        if (last_ph) begin
                            phase <= '0;
                            state <= comp_cnt ? DONE : NEXT;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (!Empty) begin
                        state <= CALC;
                        phase <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/intpol2_d4_ctrl_fsm.md
# intpol2_D4_ctrl_fsm

Control state machine for the second-order, factor-4 interpolator. It sits directly upstream of the interpolator's next-state logic block and drives that block's `busy`, `en_M_addr`, `en_sum`, `done`, `Read_Enable` and `Write_Enable` strobes. It consumes the next-state block's `comp_addr` (prefetch complete) and `comp_cnt` (last input sample) flags. It also gates all traffic against input-FIFO `Empty` and output-FIFO `Afull`.

## Interface
- `PH_BITS`, default 2: phase counter width; outputs per input sample = 2^PH_BITS (4).
- `clk` in, 1: system clock, rising edge.
- `rstn` in, 1: asynchronous reset, active low.
- `clear` in, 1: synchronous abort to IDLE.
- `start` in, 1: one-cycle launch request; sampled only in IDLE.
- `mode` in, 1: 0 = interpolate (2^PH_BITS writes per input); 1 = pass-through (1 write per input). Sampled at start, held internally.
- `Empty` in, 1: input FIFO empty.
- `Afull` in, 1: output FIFO almost full.
- `comp_addr` in, 1: 3-sample window prefetch complete (from next-state block).
- `comp_cnt` in, 1: current input is the last one (from next-state block).
- `busy` out, 1: run in progress.
- `done` out, 1: one-cycle end-of-run pulse.
- `en_M_addr` out, 1: enables the prefetch address counter in the next-state block.
- `Read_Enable` out, 1: pop input FIFO.
- `Write_Enable` out, 1: push output FIFO.
- `en_sum` out, 1: advance input-sample counter.
- `phase` out, PH_BITS: current output phase within the sample.

## Operation
- Registered state: {IDLE, FILL, LOAD, CALC, NEXT, DONE}, plus `phase` and `mode_r`. All outputs are combinational decodes of state, `phase`, and the current inputs.
- IDLE: all outputs 0. On `start`: latch `mode_r`, go to FILL.
- FILL: `busy`=1. Go to LOAD when `Empty`=0.
- LOAD: `busy`=1.
  - If `Empty`=1 and `comp_addr`=0: go to FILL with `en_M_addr`=0. The prefetch counter restarts from 0.
  - Otherwise: `en_M_addr`=1 and `Read_Enable`=~`comp_addr`.
  - When `comp_addr`=1: go to CALC with `phase`=0.
- CALC: `busy`=1; `Write_Enable`=~`Afull`.
  - On each write, `phase` increments.
  - The last phase is 2^PH_BITS−1 when `mode_r`=0, and 0 when `mode_r`=1.
  - On the write at the last phase: `en_sum`=1; go to DONE if `comp_cnt`=1, else to NEXT.
  - `comp_cnt` is sampled in the same cycle, before `en_sum` takes effect.
- NEXT: `busy`=1; `Read_Enable`=~`Empty`. When `Empty`=0: go to CALC with `phase`=0.
- DONE: `done`=1, `busy`=0; go to IDLE next cycle.
- `start` is ignored outside IDLE.
- `clear` has priority over all transitions: next state IDLE, `phase`=0, and no `done` pulse is emitted.
- `Afull` stalls CALC indefinitely: `phase` holds and no `en_sum` is issued.
- `Empty` stalls NEXT/FILL indefinitely.

## Timing
- Reset (`rstn`=0, asynchronous): state IDLE, `phase`=0, `mode_r`=0. All outputs are 0 immediately.
- `start` high at edge N: FILL in cycle N+1, or LOAD in N+2 if the input FIFO is non-empty.
- Prefetch: 3 cycles with `en_M_addr`=1 and `Read_Enable`=1. `comp_addr` rises in the 4th LOAD cycle. CALC starts the following cycle.
- No-stall throughput, `mode_r`=0: 4 writes in CALC plus 1 NEXT cycle = 5 cycles per input. With `mode_r`=1: 2 cycles per input.
- `en_sum` coincides exactly with the final-phase `Write_Enable` of each sample.
- `done` asserts the cycle after the last `Write_Enable` and lasts exactly 1 cycle.
- Reset or `clear` mid-run: outputs drop to 0 in the same cycle (reset) or the next cycle (clear). A fresh `start` is needed to run again.

## Test plan
- Reset/idle: hold `rstn`=0 and then release with no `start` -> all outputs 0 and state IDLE for 20 cycles.
- Normal run, `mode`=0, FIFOs free, `comp_cnt` rising on the 3rd `en_sum`:
  - 3 reads during prefetch, then 2 reads in NEXT.
  - Exactly 12 `Write_Enable` pulses and 3 `en_sum` pulses.
  - `phase` sequence 0,1,2,3 per sample.
  - `done` is a single pulse one cycle after the 12th write.
- Pass-through, `mode`=1, 4 samples: 4 writes, 4 `en_sum`, with `en_sum` on every write.
- Backpressure: `Afull`=1 for 5 cycles at `phase`=2 -> no writes, `phase` stays 2, and there is no `en_sum`. Resumes at 2 and finishes with the identical total write count.
- Underflow in LOAD: `Empty` rises after the 2nd prefetch read -> `en_M_addr` drops, FILL is entered, and the prefetch restarts with 3 fresh reads once `Empty`=0.
- `clear` asserted mid-CALC -> IDLE next cycle with no `done` pulse. A later `start` runs a complete, correct sequence.
